// File: rtl/registers_pkg.sv
// rtl/registers_pkg.sv - shared states, frame constants and standard UART configuration
package registers_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_REQ,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_SEND_RETRY,
        ST_APPLY,
        ST_SEND_ACK,
        ST_WAIT_ACK_TX,
        ST_FINISH
    } cfg_state_t;

    typedef struct packed {
        logic [1:0] dwid;
        logic [1:0] pmid;
        logic [1:0] sbid;
    } cfg_fields_t;

    localparam logic [1:0] CFG_REQ_MARKER = 2'b11;
    localparam logic [7:0] CFG_ACK_BYTE   = 8'hA5;

    localparam logic [1:0] STD_DWID = 2'b11;
    localparam logic [1:0] STD_PMID = 2'b00;
    localparam logic [1:0] STD_SBID = 2'b00;

    localparam cfg_fields_t STD_CONFIGURATION = '{dwid: STD_DWID, pmid: STD_PMID, sbid: STD_SBID};

    function automatic logic [7:0] req_frame(input cfg_fields_t f);
        return {CFG_REQ_MARKER, f};
    endfunction

endpackage

// File: rtl/cfg_timeout_counter.sv
// rtl/cfg_timeout_counter.sv - saturating ACK-wait counter with expiry flag
module cfg_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/config_handshake_ctrl.sv
// rtl/config_handshake_ctrl.sv - UART configuration exchange FSM; retries built only with CONFIG_RETRY_EN
module config_handshake_ctrl
    import registers_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_config_i,
    input  logic       send_config_req_i,
    input  logic       set_std_config_i,
    input  logic       ack_request_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] parity_mode_i,
    input  logic [1:0] stop_bits_i,
    output logic       str_en_o,
    output logic [1:0] data_width_o,
    output logic [1:0] parity_mode_o,
    output logic [1:0] stop_bits_o,
    output logic       config_done_o,
    output logic       config_error_o,
    output logic [7:0] tx_data_o,
    output logic       tx_req_o,
    input  logic       tx_done_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i
);

    cfg_state_t  state;
    cfg_fields_t cfg;
    cfg_fields_t str_fields;
    cfg_fields_t local_fields;
    cfg_fields_t rx_fields;
    logic        rx_is_req;
    logic        rx_is_ack;
    logic        tmo_expired;

`ifdef CONFIG_RETRY_EN
    localparam int RW = $clog2(MAX_RETRIES + 2);
    logic [RW-1:0] retries;
`else
    localparam int unused_max_retries = MAX_RETRIES;
`endif

    assign local_fields = set_std_config_i ? STD_CONFIGURATION
                                           : cfg_fields_t'({data_width_i, parity_mode_i, stop_bits_i});
    assign rx_fields    = cfg_fields_t'(rx_data_i[5:0]);
    assign rx_is_req    = rx_valid_i && (rx_data_i[7:6] == CFG_REQ_MARKER);
    assign rx_is_ack    = rx_valid_i && (rx_data_i == CFG_ACK_BYTE);

    assign data_width_o  = str_fields.dwid;
    assign parity_mode_o = str_fields.pmid;
    assign stop_bits_o   = str_fields.sbid;

    // Counter runs only while waiting for ACK, so every entry to WAIT_ACK starts from zero.
    cfg_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .clear  (state != ST_WAIT_ACK),
        .enable (state == ST_WAIT_ACK),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state          <= ST_IDLE;
            cfg            <= STD_CONFIGURATION;
            str_fields     <= STD_CONFIGURATION;
            str_en_o       <= 1'b0;
            tx_req_o       <= 1'b0;
            tx_data_o      <= 8'h00;
            config_done_o  <= 1'b1;
            config_error_o <= 1'b0;
`ifdef CONFIG_RETRY_EN
            retries        <= '0;
`endif
        end else begin
            str_en_o <= 1'b0;
            tx_req_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable_config_i) begin
                        // Partner's request wins over a local one arriving in the same cycle.
                        if (rx_is_req) begin
                            state         <= ST_APPLY;
                            cfg           <= rx_fields;
                            str_fields    <= rx_fields;
                            str_en_o      <= 1'b1;
                            config_done_o <= 1'b0;
                        end else if (set_std_config_i || send_config_req_i) begin
                            state          <= ST_SEND_REQ;
                            cfg            <= local_fields;
                            tx_req_o       <= 1'b1;
                            tx_data_o      <= req_frame(local_fields);
                            config_done_o  <= 1'b0;
                            config_error_o <= 1'b0;
`ifdef CONFIG_RETRY_EN
                            retries        <= '0;
`endif
                        end
                    end
                end
                ST_SEND_REQ: state <= ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (tx_done_i) state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (rx_is_ack) begin
                        state          <= ST_FINISH;
                        str_fields     <= cfg;
                        str_en_o       <= 1'b1;
                        config_error_o <= 1'b0;
                    end else if (tmo_expired) begin
`ifdef CONFIG_RETRY_EN
                        if (retries < RW'(MAX_RETRIES)) begin
                            retries <= retries + 1'b1;
                            state   <= ST_SEND_RETRY;
                        end else begin
                            state          <= ST_IDLE;
                            config_error_o <= 1'b1;
                            config_done_o  <= 1'b1;
                        end
`else
                        state          <= ST_IDLE;
                        config_error_o <= 1'b1;
                        config_done_o  <= 1'b1;
`endif
                    end
                end
                ST_SEND_RETRY: begin
                    state     <= ST_SEND_REQ;
                    tx_req_o  <= 1'b1;
                    tx_data_o <= req_frame(cfg);
                end
                ST_APPLY: begin
                    if (ack_request_i) begin
                        state     <= ST_SEND_ACK;
                        tx_req_o  <= 1'b1;
                        tx_data_o <= CFG_ACK_BYTE;
                    end else begin
                        state         <= ST_IDLE;
                        config_done_o <= 1'b1;
                    end
                end
                ST_SEND_ACK: state <= ST_WAIT_ACK_TX;
                ST_WAIT_ACK_TX: begin
                    if (tx_done_i) begin
                        state         <= ST_IDLE;
                        config_done_o <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state         <= ST_IDLE;
                    config_done_o <= 1'b1;
                end
                default: begin
                    state         <= ST_IDLE;
                    config_done_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_handshake_ctrl.sv
// tb/tb_config_handshake_ctrl.sv - cycle-timeline model bench for config_handshake_ctrl
module tb_config_handshake_ctrl;

    localparam int TMO  = 16;
    localparam int MAXR = 2;
    localparam int NC   = 1024;
`ifdef CONFIG_RETRY_EN
    localparam int RETRIES = MAXR;
`else
    localparam int RETRIES = 0;
`endif
    localparam logic [5:0] STD = 6'b110000;

    logic       clk = 1'b0;
    logic       rst_n, en, sreq, stdc, akreq, tx_done, rx_valid;
    logic [1:0] dw, pm, sb;
    logic [7:0] rx_data;
    logic       str_en, done, err, tx_req;
    logic [1:0] dw_o, pm_o, sb_o;
    logic [7:0] tx_data;

    config_handshake_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_config_i(en),
        .send_config_req_i(sreq), .set_std_config_i(stdc), .ack_request_i(akreq),
        .data_width_i(dw), .parity_mode_i(pm), .stop_bits_i(sb),
        .str_en_o(str_en), .data_width_o(dw_o), .parity_mode_o(pm_o), .stop_bits_o(sb_o),
        .config_done_o(done), .config_error_o(err),
        .tx_data_o(tx_data), .tx_req_o(tx_req), .tx_done_i(tx_done),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output timeline, one entry per clock cycle.
    logic       exp_done[NC], exp_txreq[NC], exp_str[NC], exp_err[NC];
    logic [7:0] exp_txdata[NC];
    logic [5:0] exp_fields[NC];

    int nvec = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < NC) begin
            check("config_done", {7'd0, done}, {7'd0, exp_done[cyc]});
            check("config_error", {7'd0, err}, {7'd0, exp_err[cyc]});
            check("tx_req", {7'd0, tx_req}, {7'd0, exp_txreq[cyc]});
            check("tx_data", tx_data, exp_txdata[cyc]);
            check("str_en", {7'd0, str_en}, {7'd0, exp_str[cyc]});
            check("fields", {2'd0, dw_o, pm_o, sb_o}, {2'd0, exp_fields[cyc]});
        end
    end

    task automatic done_range(input int a, input int b, input logic v);
        for (int i = a; i <= b && i < NC; i++) exp_done[i] = v;
    endtask
    task automatic err_from(input int c, input logic v);
        for (int i = c; i < NC; i++) exp_err[i] = v;
    endtask
    task automatic txdata_from(input int c, input logic [7:0] v);
        for (int i = c; i < NC; i++) exp_txdata[i] = v;
    endtask
    task automatic fields_from(input int c, input logic [5:0] v);
        for (int i = c; i < NC; i++) exp_fields[i] = v;
    endtask
    task automatic tx_pulse(input int c, input logic [7:0] d);
        exp_txreq[c] = 1'b1;
        txdata_from(c, d);
    endtask
    task automatic str_pulse(input int c, input logic [5:0] f);
        exp_str[c] = 1'b1;
        fields_from(c, f);
    endtask
    function automatic int count_tx(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (exp_txreq[i]) n++;
        return n;
    endfunction

    task automatic goto(input int c);
        if (cyc > c) begin
            nvec++; nfail++;
            $display("FAIL schedule: at cycle %0d expected to reach %0d", cyc, c);
        end
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic step1;
        @(posedge clk); #1;
    endtask

    // Initiator: REQ frame one cycle after request, tx_done two cycles later,
    // WAIT_ACK entered the cycle after tx_done, ACK answered or timed out.
    task automatic initiator(input logic use_std, input logic [5:0] f, input int ack_after,
                             input bit junk, input bit drop_en, output int tx_first, output int end_c);
        int n, tx_c, e, a, att;
        logic [5:0] sel;
        int td[$];
        n = cyc;
        sel = use_std ? STD : f;
        tx_c = n + 1;
        tx_first = tx_c;
        err_from(n + 1, 1'b0);
        att = 0;
        a = 0;
        forever begin
            tx_pulse(tx_c, {2'b11, sel});
            td.push_back(tx_c + 2);
            e = tx_c + 3;
            if (ack_after >= 0) begin
                a = e + ack_after;
                str_pulse(a + 1, sel);
                done_range(n + 1, a + 1, 1'b0);
                end_c = a + 2;
                break;
            end
            if (att < RETRIES) begin
                att++;
                tx_c = e + TMO + 1;
            end else begin
                err_from(e + TMO, 1'b1);
                done_range(n + 1, e + TMO - 1, 1'b0);
                end_c = e + TMO;
                break;
            end
        end
        sreq = 1'b1; stdc = use_std; {dw, pm, sb} = f;
        step1;
        sreq = 1'b0; stdc = 1'b0;
        if (drop_en) en = 1'b0;
        foreach (td[i]) begin
            goto(td[i]);
            tx_done = 1'b1; step1; tx_done = 1'b0;
        end
        if (ack_after >= 0) begin
            if (junk) begin
                goto(e);
                rx_data = 8'h3C; rx_valid = 1'b1; step1; rx_valid = 1'b0;
            end
            goto(a);
            rx_data = 8'hA5; rx_valid = 1'b1; step1; rx_valid = 1'b0;
        end
        goto(end_c);
        en = 1'b1;
    endtask

    // Responder: APPLY the cycle after the REQ byte, ACK frame the cycle after that.
    task automatic responder(input logic [7:0] b, input logic ak, input logic also_sreq, output int r);
        r = cyc;
        str_pulse(r + 1, b[5:0]);
        if (ak) begin
            tx_pulse(r + 2, 8'hA5);
            done_range(r + 1, r + 4, 1'b0);
        end else begin
            done_range(r + 1, r + 1, 1'b0);
        end
        rx_data = b; rx_valid = 1'b1; akreq = ak; sreq = also_sreq;
        step1;
        rx_valid = 1'b0; sreq = 1'b0;
        if (ak) begin
            goto(r + 4);
            tx_done = 1'b1; step1; tx_done = 1'b0;
        end
        goto(r + 6);
        akreq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, ec, r, n;
        for (int i = 0; i < NC; i++) begin
            exp_done[i] = 1'b1; exp_txreq[i] = 1'b0; exp_str[i] = 1'b0; exp_err[i] = 1'b0;
            exp_txdata[i] = 8'h00; exp_fields[i] = STD;
        end
        rst_n = 1'b0; en = 1'b1; sreq = 1'b0; stdc = 1'b0; akreq = 1'b0;
        tx_done = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; dw = 2'b00; pm = 2'b00; sb = 2'b00;
        goto(1);
        chk_en = 1'b1;
        check("reset_done", {7'd0, done}, 8'h01);
        check("reset_err", {7'd0, err}, 8'h00);
        check("reset_txdata", tx_data, 8'h00);
        check("reset_fields", {2'd0, dw_o, pm_o, sb_o}, 8'h30);
        goto(3);
        rst_n = 1'b1;
        goto(5);

        // SREQ with 8-bit/even/1-stop
        initiator(1'b0, 6'b110100, 2, 1'b0, 1'b0, t, ec);
        check("pin_sreq_frame", exp_txdata[t], 8'hF4);
        check("pin_sreq_fields", {2'd0, exp_fields[ec]}, 8'h34);
        goto(cyc + 2);

        // STDC together with SREQ: standard frame wins
        initiator(1'b1, 6'b010101, 0, 1'b0, 1'b0, t, ec);
        check("pin_std_frame", exp_txdata[t], 8'hF0);
        check("pin_std_fields", {2'd0, exp_fields[ec]}, 8'h30);
        goto(cyc + 2);

        // Responder with ACK, then without
        responder(8'hD9, 1'b1, 1'b0, r);
        check("pin_resp_fields", {2'd0, exp_fields[r + 1]}, 8'h19);
        check("pin_resp_ack", exp_txdata[r + 2], 8'hA5);
        responder(8'hD9, 1'b0, 1'b0, r);
        check("pin_resp_noack", count_tx(r, r + 5), 8'h00);
        // Received REQ beats a simultaneous local SREQ
        responder(8'hE6, 1'b0, 1'b1, r);
        check("pin_prio_fields", {2'd0, exp_fields[r + 2]}, 8'h26);

        // Disabled controller ignores both request kinds
        en = 1'b0; sreq = 1'b1; rx_data = 8'hC3; rx_valid = 1'b1;
        step1;
        sreq = 1'b0; rx_valid = 1'b0;
        goto(cyc + 3);
        en = 1'b1;

        // Junk byte ignored in WAIT_ACK; enable dropped mid-sequence
        initiator(1'b0, 6'b000110, 3, 1'b1, 1'b1, t, ec);
        check("pin_junk_frame", exp_txdata[t], 8'hC6);
        goto(cyc + 2);

        // No ACK: timeout (with retries when built in)
        initiator(1'b0, 6'b011010, -1, 1'b0, 1'b0, t, ec);
        check("pin_tmo_frames", count_tx(t, ec), 8'(RETRIES + 1));
        check("pin_tmo_err_before", {7'd0, exp_err[ec - 1]}, 8'h00);
        check("pin_tmo_err_at", {7'd0, exp_err[ec]}, 8'h01);
        check("pin_tmo_nostr", {7'd0, exp_str[ec - 1]}, 8'h00);
        goto(cyc + 2);

        // New initiator sequence clears the sticky error
        initiator(1'b0, 6'b101101, 1, 1'b0, 1'b0, t, ec);
        check("pin_clr_err", {7'd0, exp_err[t]}, 8'h00);
        goto(cyc + 2);

        // Reset asserted during WAIT_TX; a later tx_done is ignored
        n = cyc;
        tx_pulse(n + 1, 8'hF4);
        done_range(n + 1, n + 2, 1'b0);
        err_from(n + 1, 1'b0);
        txdata_from(n + 3, 8'h00);
        fields_from(n + 3, STD);
        sreq = 1'b1; {dw, pm, sb} = 6'b110100;
        step1;
        sreq = 1'b0;
        goto(n + 2);
        rst_n = 1'b0;
        step1;
        rst_n = 1'b1;
        check("rst_wait_tx_done", {7'd0, done}, 8'h01);
        check("rst_wait_tx_txreq", {7'd0, tx_req}, 8'h00);
        goto(n + 5);
        tx_done = 1'b1; step1; tx_done = 1'b0;
        goto(n + 10);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/config_handshake_ctrl.md
# config_handshake_ctrl

Sequences the UART configuration exchange between two link partners. It is driven by the CTR request bits (SREQ, STDC, AKREQ, ENREQ), transmits and receives configuration frames through the TX/RX byte paths, and writes negotiated fields back into STR through the STR enable path. It also produces the CDONE status bit and sits beside the configuration register file in the UART top level.

## Interface
Parameters:
- TIMEOUT_CYCLES, 50000, clock cycles to wait for an ACK frame after a REQ frame is sent.
- MAX_RETRIES, 3, extra REQ transmissions after a timeout (used only with the retry feature).

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_n_i  in  1  synchronous active-low reset, sampled on the rising edge of clk_i.
- enable_config_i  in  1  CTR.ENREQ; the controller acts only while this is high.
- send_config_req_i  in  1  CTR.SREQ; start as initiator with the current STR fields.
- set_std_config_i  in  1  CTR.STDC; start as initiator with the standard configuration.
- ack_request_i  in  1  CTR.AKREQ; as responder, answer with an ACK frame.
- data_width_i / parity_mode_i / stop_bits_i  in  2 each  current STR fields.
- str_en_o  out  1  one-cycle write strobe into STR.
- data_width_o / parity_mode_o / stop_bits_o  out  2 each  fields written on str_en_o.
- config_done_o  out  1  high when idle or finished (feeds CTR.CDONE).
- config_error_o  out  1  sticky flag: the last initiated sequence timed out.
- tx_data_o  out  8  frame byte to the transmitter.
- tx_req_o  out  1  one-cycle transmit request.
- tx_done_i  in  1  one-cycle pulse when the transmitter has finished the byte.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle pulse when rx_data_i is valid.

## Operation
Frame formats:
- REQ frame = {2'b11, DWID, PMID, SBID}.
- ACK frame = 8'hA5.

States and transitions:
- IDLE: config_done_o=1. Requests are honoured only when enable_config_i=1.
  - A received REQ frame (rx_valid_i & rx_data_i[7:6]==2'b11) → APPLY. Responder has priority over a local request in the same cycle.
  - Otherwise set_std_config_i → SEND_REQ with the STD fields. STDC takes priority over SREQ.
  - Otherwise send_config_req_i → SEND_REQ with the STR input fields.
  - The selected fields are latched into an internal config register on the transition.
- SEND_REQ: tx_req_o=1 for one cycle; tx_data_o = REQ frame built from the latched fields; → WAIT_TX.
- WAIT_TX: hold until tx_done_i; → WAIT_ACK; timeout counter cleared.
- WAIT_ACK: counter increments each cycle.
  - rx_valid_i & rx_data_i==8'hA5 → FINISH.
  - Any other received byte is ignored and the counter keeps running.
  - Counter == TIMEOUT_CYCLES-1 → error path (see Configuration).
- APPLY: str_en_o=1 for one cycle with the fields decoded from the received frame; → SEND_ACK if ack_request_i, else → IDLE.
- SEND_ACK: tx_req_o=1, tx_data_o=8'hA5; → WAIT_ACK_TX.
- WAIT_ACK_TX: wait for tx_done_i; → IDLE.
- FINISH: str_en_o=1 for one cycle with the latched fields; config_error_o cleared; → IDLE.

Other rules:
- config_done_o=0 in every state except IDLE.
- config_error_o is cleared when a new initiator sequence starts.
- enable_config_i dropping mid-sequence has no effect; the sequence runs to completion.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

## Timing
Reset values:
- State = IDLE.
- config_done_o=1, config_error_o=0, str_en_o=0, tx_req_o=0.
- tx_data_o=8'h00; field outputs = STD values.
- Retry counter and timeout counter = 0.

Latencies (all outputs registered):
- Request sampled in cycle N → tx_req_o high in cycle N+1.
- Matching ACK byte in cycle N → str_en_o high in N+1, config_done_o high in N+2.
- Received REQ byte in cycle N → str_en_o high in N+1; ACK tx_req_o high in N+2 if ack_request_i=1.

Reset asserted in any state returns the block to IDLE on the next edge, with the reset values above.

## Configuration
- CONFIG_RETRY_EN defined: on timeout, if retries < MAX_RETRIES, increment the retry counter and go to SEND_RETRY → SEND_REQ. The same frame is resent and the timeout counter is cleared. When retries are exhausted, set config_error_o and go to IDLE.
- CONFIG_RETRY_EN undefined: the first timeout sets config_error_o and goes to IDLE. No retry counter is built.
- In both cases, STR is not written on failure.

## Structure
Shared package (registers_pkg) holds:
- state enum cfg_state_t;
- CFG_REQ_MARKER (2'b11) and CFG_ACK_BYTE (8'hA5);
- STD_DWID = 2'b11, STD_PMID = 2'b00, STD_SBID = 2'b00, consistent with STD_CONFIGURATION.

A sub-module cfg_timeout_counter (clear, enable, expired) is natural. All other logic stays in a single FSM module.

## Test plan
- SREQ with STR = 8-bit/even/1-stop (11/01/00): expect tx_data_o=8'hF4. After tx_done_i, inject 8'hA5 → str_en_o pulse with the same fields, config_done_o returns to 1, config_error_o=0.
- STDC and SREQ asserted together: expect tx_data_o=8'hF0 (STD frame). After ACK, str_en_o writes 11/00/00.
- Responder: inject 8'hD9 with ack_request_i=1 → str_en_o with 01/10/01, then tx_req_o with 8'hA5. Repeat with ack_request_i=0 → no transmission.
- TIMEOUT_CYCLES=16, no ACK:
  - without the macro → config_error_o=1 exactly 16 cycles after WAIT_ACK entry, no str_en_o;
  - with CONFIG_RETRY_EN and MAX_RETRIES=2 → exactly 3 REQ frames, then config_error_o=1.
- In WAIT_ACK, inject 8'h3C then 8'hA5 → first byte ignored, completion on the second.
- Reset asserted during WAIT_TX → next cycle IDLE, config_done_o=1, tx_req_o=0; a later tx_done_i pulse is ignored.
